// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control stage and the ALU itself.
//   - ALU operation codes (ALUCtrl), main-control class codes (ALUOp)
//   - R-type funct field constants
//   - control-stage state encoding
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_MUL = 3'b011,
        ALU_SUB = 3'b110,
        ALU_ILL = 3'b111   // ALU drives 0 for this code
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_MULWAIT = 2'b01,
        ST_FULL    = 2'b10
    } stage_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode.
// Ports:
//   ALUOp_i   [1:0]  main-control class
//   funct_i   [5:0]  R-type function field
//   ALUCtrl_o [2:0]  ALU operation code
//   illegal_o        funct not decodable (R-type only)
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp_i,
    input  logic [5:0] funct_i,
    output logic [2:0] ALUCtrl_o,
    output logic       illegal_o
);

    always_comb begin
        ALUCtrl_o = ALU_ILL;
        illegal_o = 1'b0;
        case (ALUOp_i)
            ALUOP_ADD: ALUCtrl_o = ALU_ADD;
            ALUOP_SUB: ALUCtrl_o = ALU_SUB;
            ALUOP_OR:  ALUCtrl_o = ALU_OR;
            default: begin
                case (funct_i)
                    FUNCT_ADD: ALUCtrl_o = ALU_ADD;
                    FUNCT_SUB: ALUCtrl_o = ALU_SUB;
                    FUNCT_AND: ALUCtrl_o = ALU_AND;
                    FUNCT_OR:  ALUCtrl_o = ALU_OR;
                    FUNCT_MUL: ALUCtrl_o = ALU_MUL;
                    default: begin
                        ALUCtrl_o = ALU_ILL;
                        illegal_o = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ALU control pipeline stage: decodes ALUOp/funct and holds one beat
// toward the ALU with valid/ready handshakes on both sides. MUL beats
// are held back MUL_WAIT cycles before being offered downstream.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   EMPTY   | no beat held; accepting upstream
//   MULWAIT | MUL beat held, counting down before offering it
//   FULL    | beat offered downstream; accepts a new one on retire
//
// Ports:
//   clk_i, rst_i (sync, active-low)
//   valid_i/ready_o, ALUOp_i, funct_i, data1_i, data2_i, rd_i  upstream
//   flush_i                                                    discard
//   valid_o/ready_i, ALUCtrl_o, data1_o, data2_o, rd_o, illegal_o downstream
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_WAIT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  ALUOp_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [2:0]  ALUCtrl_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [4:0]  rd_o,
    output logic        illegal_o
);

    localparam logic [2:0] MUL_LOAD = (MUL_WAIT == 0) ? 3'd0 : 3'(MUL_WAIT - 1);

    stage_state_e state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [2:0]   dec_code;
    logic         dec_illegal;
    logic         capture;
    logic         to_mulwait;

    alu_ctrl_decode u_decode (
        .ALUOp_i   (ALUOp_i),
        .funct_i   (funct_i),
        .ALUCtrl_o (dec_code),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        capture    = 1'b0;
        to_mulwait = (dec_code == ALU_MUL) && (MUL_WAIT != 0);

        case (state_q)
            ST_EMPTY: ready_o = 1'b1;
            ST_FULL: begin
                valid_o = 1'b1;
                ready_o = ready_i;
            end
            default: ;
        endcase

        if (flush_i)
            ready_o = 1'b0;
        capture = valid_i && ready_o && !flush_i;

        case (state_q)
            ST_EMPTY: begin
                if (capture) begin
                    state_d = to_mulwait ? ST_MULWAIT : ST_FULL;
                    cnt_d   = to_mulwait ? MUL_LOAD : 3'd0;
                end
            end
            ST_MULWAIT: begin
                if (cnt_q == 3'd0)
                    state_d = ST_FULL;
                else
                    cnt_d = cnt_q - 3'd1;
            end
            ST_FULL: begin
                if (ready_i) begin
                    if (capture) begin
                        state_d = to_mulwait ? ST_MULWAIT : ST_FULL;
                        cnt_d   = to_mulwait ? MUL_LOAD : 3'd0;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (flush_i) begin
            state_d = ST_EMPTY;
            cnt_d   = 3'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_EMPTY;
            cnt_q     <= 3'd0;
            ALUCtrl_o <= 3'b000;
            data1_o   <= 32'd0;
            data2_o   <= 32'd0;
            rd_o      <= 5'd0;
            illegal_o <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Payload only moves on capture, which keeps it stable under backpressure.
            if (capture) begin
                ALUCtrl_o <= dec_code;
                data1_o   <= data1_i;
                data2_o   <= data2_i;
                rd_o      <= rd_i;
                illegal_o <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
module tb_alu_ctrl_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  ALUOp_i;
    logic [5:0]  funct_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [2:0]  ALUCtrl_o;
    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic [4:0]  rd_o;
    logic        illegal_o;

    int n_cmp = 0;
    int n_bad = 0;

    alu_ctrl_stage #(.MUL_WAIT(2)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUOp_i   (ALUOp_i),
        .funct_i   (funct_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .rd_i      (rd_i),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .ALUCtrl_o (ALUCtrl_o),
        .data1_o   (data1_o),
        .data2_o   (data2_o),
        .rd_o      (rd_o),
        .illegal_o (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd,
                         input logic fl, input logic rdy);
        valid_i = v; ALUOp_i = op; funct_i = f;
        data1_i = d1; data2_i = d2; rd_i = rd;
        flush_i = fl; ready_i = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    logic [1:0] sw_op  [8];
    logic [5:0] sw_fn  [8];
    logic [2:0] sw_code[8];
    logic       sw_ill [8];

    initial begin
        sw_op[0] = 2'b10; sw_fn[0] = 6'h20; sw_code[0] = 3'b010; sw_ill[0] = 1'b0;
        sw_op[1] = 2'b10; sw_fn[1] = 6'h22; sw_code[1] = 3'b110; sw_ill[1] = 1'b0;
        sw_op[2] = 2'b10; sw_fn[2] = 6'h24; sw_code[2] = 3'b000; sw_ill[2] = 1'b0;
        sw_op[3] = 2'b10; sw_fn[3] = 6'h25; sw_code[3] = 3'b001; sw_ill[3] = 1'b0;
        sw_op[4] = 2'b10; sw_fn[4] = 6'h2A; sw_code[4] = 3'b111; sw_ill[4] = 1'b1;
        sw_op[5] = 2'b00; sw_fn[5] = 6'h2A; sw_code[5] = 3'b010; sw_ill[5] = 1'b0;
        sw_op[6] = 2'b01; sw_fn[6] = 6'h18; sw_code[6] = 3'b110; sw_ill[6] = 1'b0;
        sw_op[7] = 2'b11; sw_fn[7] = 6'h00; sw_code[7] = 3'b001; sw_ill[7] = 1'b0;

        // reset held two cycles with a beat presented
        rst_i = 1'b0;
        drive(1'b1, 2'b00, 6'h0, 32'hAA, 32'hBB, 5'd3, 1'b0, 1'b1);
        tick(); tick();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ctrl", 32'(ALUCtrl_o), 32'd0);
        chk("rst_d1", data1_o, 32'd0);
        chk("rst_d2", data2_o, 32'd0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        chk("rst_ill", 32'(illegal_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        chk("rst_ready_after", 32'(ready_o), 32'd1);
        tick();

        // decode sweep, back-to-back with ready_i=1
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, sw_op[i], sw_fn[i], 32'(i), 32'(i + 100), 5'(i), 1'b0, 1'b1);
            chk($sformatf("sweep%0d_ready", i), 32'(ready_o), 32'd1);
            tick();
            chk($sformatf("sweep%0d_valid", i), 32'(valid_o), 32'd1);
            chk($sformatf("sweep%0d_ctrl", i), 32'(ALUCtrl_o), 32'(sw_code[i]));
            chk($sformatf("sweep%0d_ill", i), 32'(illegal_o), 32'(sw_ill[i]));
            chk($sformatf("sweep%0d_d2", i), data2_o, 32'(i + 100));
        end
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        chk("sweep_drain", 32'(valid_o), 32'd0);

        // MUL latency with MUL_WAIT=2
        drive(1'b1, 2'b10, 6'h18, 32'h6, 32'h7, 5'd9, 1'b0, 1'b1);
        chk("mul_c0_ready", 32'(ready_o), 32'd1);
        tick();
        drive(1'b1, 2'b00, 6'h0, 32'hDEAD, 32'h0, 5'd1, 1'b0, 1'b1);
        chk("mul_c1_ready", 32'(ready_o), 32'd0);
        chk("mul_c1_valid", 32'(valid_o), 32'd0);
        tick();
        chk("mul_c2_ready", 32'(ready_o), 32'd0);
        chk("mul_c2_valid", 32'(valid_o), 32'd0);
        tick();
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        chk("mul_c3_valid", 32'(valid_o), 32'd1);
        chk("mul_c3_ctrl", 32'(ALUCtrl_o), 32'b011);
        chk("mul_c3_d1", data1_o, 32'h6);
        chk("mul_c3_rd", 32'(rd_o), 32'd9);
        tick();
        chk("mul_retired", 32'(valid_o), 32'd0);

        // backpressure: ADD held while ready_i=0, then SUB follows with no bubble
        drive(1'b1, 2'b00, 6'h0, 32'h5, 32'h3, 5'd7, 1'b0, 1'b1);
        tick();
        drive(1'b1, 2'b01, 6'h0, 32'h9, 32'h4, 5'd8, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp%0d_ready", i), 32'(ready_o), 32'd0);
            tick();
            chk($sformatf("bp%0d_valid", i), 32'(valid_o), 32'd1);
            chk($sformatf("bp%0d_ctrl", i), 32'(ALUCtrl_o), 32'b010);
            chk($sformatf("bp%0d_d1", i), data1_o, 32'h5);
            chk($sformatf("bp%0d_d2", i), data2_o, 32'h3);
            chk($sformatf("bp%0d_rd", i), 32'(rd_o), 32'd7);
        end
        drive(1'b1, 2'b01, 6'h0, 32'h9, 32'h4, 5'd8, 1'b0, 1'b1);
        chk("bp_release_ready", 32'(ready_o), 32'd1);
        tick();
        chk("bp_sub_valid", 32'(valid_o), 32'd1);
        chk("bp_sub_ctrl", 32'(ALUCtrl_o), 32'b110);
        chk("bp_sub_d1", data1_o, 32'h9);
        chk("bp_sub_rd", 32'(rd_o), 32'd8);
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();

        // flush in FULL with an incoming beat
        drive(1'b1, 2'b00, 6'h0, 32'h11, 32'h0, 5'd2, 1'b0, 1'b1);
        tick();
        drive(1'b1, 2'b11, 6'h0, 32'h22, 32'h0, 5'd4, 1'b1, 1'b1);
        chk("flush_ready", 32'(ready_o), 32'd0);
        tick();
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_no_capture", data1_o, 32'h11);
        chk("flush_empty_ready", 32'(ready_o), 32'd1);

        // flush during MULWAIT
        drive(1'b1, 2'b10, 6'h18, 32'h33, 32'h0, 5'd5, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        chk("flushmw_ready", 32'(ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("flushmw_valid%0d", i), 32'(valid_o), 32'd0);
            tick();
        end

        // reset in MULWAIT
        drive(1'b1, 2'b10, 6'h18, 32'h44, 32'h0, 5'd6, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready_o), 32'd1);
        chk("midrst_ctrl", 32'(ALUCtrl_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("midrst_valid%0d", i), 32'(valid_o), 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
